// File: rtl/gimbal_tx_sched.sv
// gimbal_tx_sched: captures target coordinates, converts them to pan/tilt angle bytes
// and sends one framed packet per tick over a shared, flow-controlled byte UART.
module gimbal_tx_sched #(
    parameter int         Z_MUL        = 56,
    parameter int         Z_SHIFT      = 10,
    parameter int         X_MUL        = 40,
    parameter int         X_DIV        = 720,
    parameter logic [7:0] HDR_BYTE     = 8'hA5,
    parameter int         BUSY_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] x_coor,
    input  logic [9:0]  y_coor,
    input  logic        coor_valid_flag,
    input  logic        tick,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        frame_done,
    output logic        tx_err,
    output logic [7:0]  ovr_cnt
);
    localparam int              TO_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [16:0]     DIV17   = 17'(X_DIV);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SEND, S_WAIT} state_t;

    state_t          r_state;
    logic [10:0]     r_hold_x;
    logic [9:0]      r_hold_y;
    logic            r_fresh;
    logic            r_pending;
    logic [9:0]      r_work_y;
    logic [7:0]      r_status;
    logic [7:0]      r_angle_z;
    logic [7:0]      r_angle_x;
    logic [15:0]     r_num;
    logic [15:0]     r_rem;
    logic [6:0]      r_quot;
    logic [4:0]      r_calc_cnt;
    logic [2:0]      r_idx;
    logic            r_skip;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_tx_data;
    logic            r_tx_en;
    logic            r_frame_done;
    logic            r_tx_err;
    logic [7:0]      r_ovr_cnt;

    // A valid pulse coinciding with the snapshot wins over the hold registers.
    logic [10:0] w_snap_x;
    logic [9:0]  w_snap_y;
    logic [31:0] w_z_prod;
    logic [7:0]  w_angle_z;
    logic [15:0] w_num;
    logic [16:0] w_rem_shift;
    logic [16:0] w_rem_sub;
    logic [16:0] w_rem_next;
    logic        w_ge;
    logic [7:0]  w_chk;
    logic [7:0]  w_byte;

    assign w_snap_x    = coor_valid_flag ? x_coor : r_hold_x;
    assign w_snap_y    = coor_valid_flag ? y_coor : r_hold_y;
    assign w_z_prod    = 32'(Z_MUL) * 32'(w_snap_x);
    assign w_angle_z   = 8'(w_z_prod >> Z_SHIFT);
    assign w_num       = 16'(X_MUL) * 16'(r_work_y);
    assign w_rem_shift = {r_rem, r_num[15]};
    assign w_ge        = (w_rem_shift >= DIV17);
    assign w_rem_sub   = w_rem_shift - DIV17;
    assign w_rem_next  = w_ge ? w_rem_sub : w_rem_shift;
    assign w_chk       = r_status + r_angle_z + r_angle_x;

    always_comb begin
        w_byte = w_chk;
        case (r_idx)
            3'd0:    w_byte = HDR_BYTE;
            3'd1:    w_byte = r_status;
            3'd2:    w_byte = r_angle_z;
            3'd3:    w_byte = r_angle_x;
            default: w_byte = w_chk;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_hold_x     <= '0;
            r_hold_y     <= '0;
            r_fresh      <= 1'b0;
            r_pending    <= 1'b0;
            r_work_y     <= '0;
            r_status     <= '0;
            r_angle_z    <= '0;
            r_angle_x    <= '0;
            r_num        <= '0;
            r_rem        <= '0;
            r_quot       <= '0;
            r_calc_cnt   <= '0;
            r_idx        <= '0;
            r_skip       <= 1'b0;
            r_to_cnt     <= '0;
            r_tx_data    <= '0;
            r_tx_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_tx_err     <= 1'b0;
            r_ovr_cnt    <= '0;
        end else begin
            r_tx_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_tx_err     <= 1'b0;

            if (coor_valid_flag) begin
                r_hold_x <= x_coor;
                r_hold_y <= y_coor;
                r_fresh  <= 1'b1;
            end

            // One request is queued while busy; further ones are counted as dropped.
            if (tick && r_state != S_IDLE) begin
                if (!r_pending)
                    r_pending <= 1'b1;
                else if (r_ovr_cnt != 8'hFF)
                    r_ovr_cnt <= r_ovr_cnt + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (tick || r_pending) begin
                        r_work_y   <= w_snap_y;
                        r_angle_z  <= w_angle_z;
                        r_status   <= {7'b0, coor_valid_flag | r_fresh};
                        r_fresh    <= 1'b0;
                        r_pending  <= 1'b0;
                        r_calc_cnt <= '0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_calc_cnt <= r_calc_cnt + 5'd1;
                    if (r_calc_cnt == 5'd0) begin
                        r_num  <= w_num;
                        r_rem  <= '0;
                        r_quot <= '0;
                    end else begin
                        // Restoring division: one quotient bit per cycle, MSB first.
                        r_num  <= {r_num[14:0], 1'b0};
                        r_rem  <= 16'(w_rem_next);
                        r_quot <= {r_quot[5:0], w_ge};
                        if (r_calc_cnt == 5'd16) begin
                            r_angle_x <= {r_quot, w_ge};
                            r_idx     <= '0;
                            r_to_cnt  <= '0;
                            r_state   <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        r_tx_data <= w_byte;
                        r_tx_en   <= 1'b1;
                        r_to_cnt  <= '0;
                        r_skip    <= 1'b1;
                        r_state   <= S_WAIT;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_tx_err <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    r_skip <= 1'b0;
                    if (!r_skip && !tx_busy) begin
                        if (r_idx == 3'd4) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= S_SEND;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_tx_err <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_en      = r_tx_en;
    assign frame_done = r_frame_done;
    assign tx_err     = r_tx_err;
    assign ovr_cnt    = r_ovr_cnt;
endmodule
